// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit:
// FSM state encoding and reset defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam int          FETCH_WIDTH    = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load, post-fetch increment and a one-cycle
// wrap pulse when the increment rolls all-ones over to zero.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             inc,
    output logic [WIDTH-1:0] pc,
    output logic             wrap
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;

    // A load always wins, so a redirect can never report a wrap.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d   = pc_q + WIDTH'(1);
            wrap_d = &pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc   = pc_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/fetch_unit.sv
// Three-state instruction fetch: address, wait for data, hold for control.
// Holds IR/instr_pc and the FSM; the PC lives in pc_reg.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd_en,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             pc_wrap
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             valid_q, valid_d;
    logic             rd_en_q, rd_en_d;
    logic             pc_inc;
    logic [WIDTH-1:0] pc;

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .load      (jump),
        .load_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc),
        .wrap      (pc_wrap)
    );

    // A redirect discards whatever is in flight or held.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        pc_inc  = 1'b0;
        if (jump) begin
            state_d = S_ADDR;
        end else begin
            unique case (state_q)
                S_ADDR: state_d = S_WAIT;
                S_WAIT: begin
                    ir_d    = mem_rdata;
                    ipc_d   = pc;
                    pc_inc  = 1'b1;
                    state_d = S_HOLD;
                end
                S_HOLD: if (instr_ready) state_d = S_ADDR;
                default: state_d = S_ADDR;
            endcase
        end
        valid_d = (state_d == S_HOLD);
        rd_en_d = (state_d == S_ADDR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ADDR;
            ir_q    <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            rd_en_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign mem_addr    = pc;
    assign mem_rd_en   = rd_en_q;
    assign instr       = ir_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a one-cycle-latency memory.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_wrap;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_wrap     (pc_wrap)
    );

    logic [15:0] mem [65536];

    always @(posedge clock)
        if (mem_rd_en) mem_rdata <= mem[mem_addr];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [15:0] ja;
        logic        rdy;
        logic        v;
        logic [15:0] ins;
        logic [15:0] ipc;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
    } vec_t;

    function automatic vec_t mk(logic rst, logic jmp, logic [15:0] ja,
                                logic rdy, logic v, logic [15:0] ins,
                                logic [15:0] ipc, logic [15:0] addr,
                                logic rd, logic wr);
        vec_t t;
        t.rst = rst; t.jmp = jmp; t.ja = ja; t.rdy = rdy;
        t.v = v; t.ins = ins; t.ipc = ipc; t.addr = addr;
        t.rd = rd; t.wr = wr;
        return t;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t tv [31];

    initial begin
        int n;
        int wraps;
        bit seen;
        for (int a = 0; a < 65536; a++) mem[a] = ~16'(a);
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h5678;
        mem[16'h0002] = 16'h9ABC;
        mem[16'h0040] = 16'hC0DE;
        mem[16'hFFFF] = 16'hBEEF;

        //          rst jmp ja       rdy v  ins       ipc       addr      rd wr
        tv[0]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
        tv[1]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
        tv[2]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        tv[3]  = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0000, 16'h0001, 0, 0);
        tv[4]  = mk(0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0001, 1, 0);
        tv[5]  = mk(0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0001, 0, 0);
        tv[6]  = mk(0, 0, 16'h0000, 1, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[7]  = mk(0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[8]  = mk(0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[9]  = mk(0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[10] = mk(0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[11] = mk(0, 0, 16'h0000, 0, 1, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[12] = mk(0, 0, 16'h0000, 1, 0, 16'h5678, 16'h0001, 16'h0002, 1, 0);
        tv[13] = mk(0, 0, 16'h0000, 1, 0, 16'h5678, 16'h0001, 16'h0002, 0, 0);
        tv[14] = mk(0, 1, 16'h0040, 1, 0, 16'h5678, 16'h0001, 16'h0040, 1, 0);
        tv[15] = mk(0, 0, 16'h0000, 1, 0, 16'h5678, 16'h0001, 16'h0040, 0, 0);
        tv[16] = mk(0, 0, 16'h0000, 1, 1, 16'hC0DE, 16'h0040, 16'h0041, 0, 0);
        tv[17] = mk(0, 1, 16'h0100, 1, 0, 16'hC0DE, 16'h0040, 16'h0100, 1, 0);
        tv[18] = mk(0, 0, 16'h0000, 1, 0, 16'hC0DE, 16'h0040, 16'h0100, 0, 0);
        tv[19] = mk(0, 0, 16'h0000, 1, 1, 16'hFEFF, 16'h0100, 16'h0101, 0, 0);
        tv[20] = mk(0, 1, 16'hFFFF, 0, 0, 16'hFEFF, 16'h0100, 16'hFFFF, 1, 0);
        tv[21] = mk(0, 0, 16'h0000, 0, 0, 16'hFEFF, 16'h0100, 16'hFFFF, 0, 0);
        tv[22] = mk(0, 0, 16'h0000, 0, 1, 16'hBEEF, 16'hFFFF, 16'h0000, 0, 1);
        tv[23] = mk(0, 0, 16'h0000, 1, 0, 16'hBEEF, 16'hFFFF, 16'h0000, 1, 0);
        tv[24] = mk(0, 0, 16'h0000, 1, 0, 16'hBEEF, 16'hFFFF, 16'h0000, 0, 0);
        tv[25] = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0000, 16'h0001, 0, 0);
        tv[26] = mk(0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0001, 1, 0);
        tv[27] = mk(0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0001, 0, 0);
        tv[28] = mk(1, 1, 16'h0040, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
        tv[29] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        tv[30] = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0000, 16'h0001, 0, 0);

        reset = 1'b1; jump = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 31; i++) begin
            reset       = tv[i].rst;
            jump        = tv[i].jmp;
            jump_addr   = tv[i].ja;
            instr_ready = tv[i].rdy;
            step();
            checks++;
            if ({instr_valid, instr, instr_pc, mem_addr, mem_rd_en, pc_wrap} !==
                {tv[i].v, tv[i].ins, tv[i].ipc, tv[i].addr, tv[i].rd, tv[i].wr}) begin
                errors++;
                $display("FAIL vec%0d: got v=%b ins=%h ipc=%h addr=%h rd=%b wr=%b expected v=%b ins=%h ipc=%h addr=%h rd=%b wr=%b",
                         i, instr_valid, instr, instr_pc, mem_addr, mem_rd_en, pc_wrap,
                         tv[i].v, tv[i].ins, tv[i].ipc, tv[i].addr, tv[i].rd, tv[i].wr);
            end
        end

        // Wrap through 0xFFFF with continuous accepts: exactly one pulse.
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            jump        = (i == 0);
            jump_addr   = 16'hFFFF;
            instr_ready = 1'b1;
            step();
            if (pc_wrap) wraps++;
        end
        chk("wrap_pulse_count", 16'(wraps), 16'd1);
        chk("wrap_end_valid", {15'd0, instr_valid}, 16'd1);

        // Redirect during the S_WAIT at 0xFFFF must not report a wrap.
        jump = 1'b1; jump_addr = 16'hFFFF; instr_ready = 1'b0;
        step();
        jump = 1'b0;
        step();
        chk("wait_at_ffff_rd", {15'd0, mem_rd_en}, 16'd0);
        jump = 1'b1; jump_addr = 16'h0002;
        step();
        jump = 1'b0;
        chk("redirect_no_wrap", {15'd0, pc_wrap}, 16'd0);
        chk("redirect_addr", mem_addr, 16'h0002);
        chk("redirect_rd", {15'd0, mem_rd_en}, 16'd1);

        n = 0;
        seen = 1'b0;
        while (!instr_valid && n < 10) begin
            step();
            if (pc_wrap) seen = 1'b1;
            n++;
        end
        chk("redirect_valid_timeout", {15'd0, instr_valid}, 16'd1);
        chk("redirect_latency", 16'(n), 16'd2);
        chk("redirect_instr", instr, 16'h9ABC);
        chk("redirect_ipc", instr_pc, 16'h0002);
        chk("redirect_wrap_seen", {15'd0, seen}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
